// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU sequencer: opcodes, FSM states and
// the bit positions of each candidate inside mux_d.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The candidate index equals the mux select value that picks it.
  localparam int MUX_AND = 0;
  localparam int MUX_OR  = 1;
  localparam int MUX_XOR = 2;
  localparam int MUX_SUM = 3;

endpackage

// File: rtl/alu_bitserial_seq_if.sv
// Bus between the sequencer, its requester/consumer and the external 4:1 mux.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends combinationally on ready, and payload is held while valid=1.
interface alu_bitserial_seq_if #(
  parameter int WIDTH = 8
);
  logic                start_valid;
  logic                start_ready;
  logic [2:0]          op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [3:0]          mux_d;
  logic [1:0]          mux_sel;
  logic                mux_out;
  logic                res_valid;
  logic                res_ready;
  logic [WIDTH-1:0]    result;
  logic                carry_out;
  logic                zero;
  alu_pkg::state_t     dbg_state;

  modport slave (
    input  start_valid, op, a, b, mux_out, res_ready,
    output start_ready, mux_d, mux_sel, res_valid, result, carry_out, zero, dbg_state
  );

  modport master (
    output start_valid, op, a, b, mux_out, res_ready,
    input  start_ready, mux_d, mux_sel, res_valid, result, carry_out, zero, dbg_state
  );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: produces the four candidate result bits and the carry
// for a single bit position of the serial datapath.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_k,
  input  logic       b_k,
  input  logic       cin,
  output logic [3:0] cand,
  output logic       cout
);

  always_comb begin
    cand          = '0;
    cand[MUX_AND] = a_k & b_k;
    cand[MUX_OR]  = a_k | b_k;
    cand[MUX_XOR] = a_k ^ b_k;
    cand[MUX_SUM] = a_k ^ b_k ^ cin;
    cout          = (a_k & b_k) | (a_k & cin) | (b_k & cin);
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: shifts operands LSB first through one bit slice,
// lets the external mux pick the result bit and reassembles the result word.
module alu_bitserial_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_bitserial_seq_if.slave    bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         sel_q, sel_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         cand;
  logic               slice_cout;

  alu_bit_slice u_slice (
    .a_k  (a_q[0]),
    .b_k  (b_q[0]),
    .cin  (carry_q),
    .cand (cand),
    .cout (slice_cout)
  );

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    sh_d            = sh_q;
    result_d        = result_q;
    sel_d           = sel_q;
    carry_d         = carry_q;
    cout_d          = cout_q;
    zero_d          = zero_q;
    cnt_d           = cnt_q;
    bus.start_ready = 1'b0;
    bus.res_valid   = 1'b0;
    bus.mux_d       = '0;
    bus.mux_sel     = '0;

    case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          a_d     = bus.a;
          b_d     = bus.op[2] ? ~bus.b : bus.b;
          sel_d   = bus.op[1:0];
          carry_d = bus.op[2];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.mux_d   = cand;
        bus.mux_sel = sel_q;
        sh_d        = {bus.mux_out, sh_q[WIDTH-1:1]};
        a_d         = a_q >> 1;
        b_d         = b_q >> 1;
        carry_d     = slice_cout;
        cnt_d       = cnt_q + 1'b1;
        // Visible outputs only change here, so they hold across RUN and IDLE.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = sh_d;
          cout_d   = (sel_q == 2'(MUX_SUM)) ? slice_cout : 1'b0;
          zero_d   = (sh_d == '0);
        end
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.zero      = zero_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq: a word-level arithmetic model
// checked every cycle, plus directed operations with hand-computed results.
module tb_alu_bitserial_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  alu_bitserial_seq_if #(.WIDTH(W)) bus();

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The external 4:1 bit-select mux.
  assign bus.mux_out = bus.mux_d[bus.mux_sel];

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int             m_k    = -1;
  bit             m_done = 1'b0;
  logic [2:0]     m_op   = '0;
  logic [W-1:0]   m_a    = '0;
  logic [W-1:0]   m_b    = '0;
  logic [W-1:0]   m_res  = '0;
  logic           m_cout = 1'b0;
  logic           m_zero = 1'b0;
  logic [W-1:0]   exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word result: {carry, result}.
  function automatic logic [W:0] model_calc(input logic [2:0] op_i, input logic [W-1:0] a_i,
                                            input logic [W-1:0] b_i);
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb = op_i[2] ? ~b_i : b_i;
    case (op_i[1:0])
      2'b00:   r = {1'b0, a_i & bb};
      2'b01:   r = {1'b0, a_i | bb};
      2'b10:   r = {1'b0, a_i ^ bb};
      default: r = {1'b0, a_i} + {1'b0, bb} + (W+1)'(op_i[2]);
    endcase
    return r;
  endfunction

  // Candidates for bit k: carry into bit k taken from a partial integer sum.
  function automatic logic [3:0] exp_mux_d(input logic [2:0] op_i, input logic [W-1:0] a_i,
                                           input logic [W-1:0] b_i, input int k);
    logic [W-1:0] bb;
    logic [63:0]  aa, bx, msk, s;
    logic         ak, bk, ck;
    bb  = op_i[2] ? ~b_i : b_i;
    aa  = 64'(a_i);
    bx  = 64'(bb);
    msk = (64'd1 << k) - 64'd1;
    s   = (aa & msk) + (bx & msk) + 64'(op_i[2]);
    ck  = s[k];
    ak  = aa[k];
    bk  = bx[k];
    return {ak ^ bk ^ ck, ak ^ bk, ak | bk, ak & bk};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k    = -1;
      m_done = 1'b0;
      m_res  = '0;
      m_cout = 1'b0;
      m_zero = 1'b0;
      exp_q.delete();
    end else if (m_done) begin
      if (bus.res_ready) m_done = 1'b0;
    end else if (m_k >= 0) begin
      if (m_k == W - 1) begin
        m_k    = -1;
        m_done = 1'b1;
        {m_cout, m_res} = model_calc(m_op, m_a, m_b);
        m_zero = (m_res == '0);
        exp_q.push_back(m_res);
      end else begin
        m_k++;
      end
    end else if (bus.start_valid) begin
      m_op = bus.op;
      m_a  = bus.a;
      m_b  = bus.b;
      m_k  = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit running;
    if (chk_en) begin
      running = (m_k >= 0);
      check("cmp_start_ready", bus.start_ready, !m_done && !running);
      check("cmp_res_valid",   bus.res_valid,   m_done);
      check("cmp_result",      bus.result,      m_res);
      check("cmp_carry_out",   bus.carry_out,   m_cout);
      check("cmp_zero",        bus.zero,        m_zero);
      check("cmp_mux_sel",     bus.mux_sel,     running ? m_op[1:0] : 2'b00);
      check("cmp_mux_d",       bus.mux_d,       running ? exp_mux_d(m_op, m_a, m_b, m_k) : 4'b0000);
    end
  end

  // ---------------- driver ----------------
  // Called and returns at a negedge; leaves res_ready=1 and the DUT idle.
  task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [W-1:0] exp_res, input logic exp_c, input logic exp_z,
                        input int hold, input bit poke);
    int n;
    int guard;
    guard = 0;
    while (bus.start_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("start_ready_wait", bus.start_ready, 1'b1);
    bus.op          = op_i;
    bus.a           = a_i;
    bus.b           = b_i;
    bus.start_valid = 1'b1;
    bus.res_ready   = (hold == 0);
    @(negedge clk);
    bus.start_valid = 1'b0;
    n = 1;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      check("run_start_ready", bus.start_ready, 1'b0);
      if (poke) begin
        if (n == 3) begin
          bus.start_valid = 1'b1;
          bus.op          = OP_ADD;
          bus.a           = '1;
          bus.b           = '1;
        end else begin
          bus.start_valid = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.start_valid = 1'b0;
    check("latency", n, W + 1);
    check("lit_result", bus.result, exp_res);
    check("lit_carry",  bus.carry_out, exp_c);
    check("lit_zero",   bus.zero, exp_z);
    check("done_start_ready", bus.start_ready, 1'b0);
    if (exp_q.size() == 0) check("sb_empty", 1'b0, 1'b1);
    else                   check("sb_result", bus.result, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = (poke && i == 0);
      @(negedge clk);
      check("hold_res_valid", bus.res_valid, 1'b1);
      check("hold_result", bus.result, exp_res);
      check("hold_start_ready", bus.start_ready, 1'b0);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(negedge clk);
    check("post_res_valid", bus.res_valid, 1'b0);
    check("post_start_ready", bus.start_ready, 1'b1);
    check("post_result_kept", bus.result, exp_res);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.op          = '0;
    bus.a           = '0;
    bus.b           = '0;
    bus.res_ready   = 1'b1;
    rst             = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_start_ready", bus.start_ready, 1'b1);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_result", bus.result, 8'h00);
    check("rst_mux_d", bus.mux_d, 4'h0);
    rst = 1'b0;

    run_op(OP_ADD, 8'h3C, 8'h0A, 8'h46, 1'b0, 1'b0, 0, 1'b0);
    run_op(OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
    run_op(OP_SUB, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 0, 1'b0);
    run_op(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    run_op(OP_AND, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 0, 1'b0);
    run_op(OP_OR,  8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 0, 1'b0);
    run_op(OP_XOR, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 0, 1'b0);
    run_op(3'b100, 8'hA5, 8'h0F, 8'hA0, 1'b0, 1'b0, 0, 1'b0);
    run_op(OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 5, 1'b1);

    // Abort an operation with reset in its 4th bit cycle.
    bus.op          = OP_ADD;
    bus.a           = 8'h12;
    bus.b           = 8'h34;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_start_ready", bus.start_ready, 1'b1);
    check("abort_res_valid", bus.res_valid, 1'b0);
    check("abort_result", bus.result, 8'h00);
    check("abort_carry", bus.carry_out, 1'b0);
    check("abort_zero", bus.zero, 1'b0);
    check("abort_mux_d", bus.mux_d, 4'h0);
    check("abort_mux_sel", bus.mux_sel, 2'b00);
    rst = 1'b0;
    run_op(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
